serial_frame_tx: RTL and testbench

//   Serial frame transmitter. It is the sending end of the "three consecutive 1s"

---
 rtl/serial_frame_tx.sv | 125 ++++++++++++
 tb/tb_serial_frame_tx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Serial frame transmitter. Each frame is the sync preamble 111,
//               then the payload MSB-first with a 0 stuffed after every two
//               consecutive 1s, then a single 0 end bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              bit_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    // state_q names the frame field currently shown on bit_out
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] ENDB = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [1:0]        run_q,       run_d;
    logic [1:0]        sync_cnt_q,  sync_cnt_d;
    logic              bit_out_q,   bit_out_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic              w_emit;
    logic [1:0]        w_run;

    assign tx_ready   = (state_q == IDLE) && !reset;
    assign bit_out    = bit_out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // The edge ending the third sync bit already emits the first payload bit.
    assign w_emit = (state_q == DATA) || ((state_q == SYNC) && (sync_cnt_q == 2'd3));
    assign w_run  = (state_q == SYNC) ? 2'd0 : run_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        run_d       = run_q;
        sync_cnt_d  = sync_cnt_q;
        bit_out_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d     = SYNC;
                    shift_d     = tx_data;
                    bits_left_d = CNT_FULL;
                    run_d       = 2'd0;
                    sync_cnt_d  = 2'd1;
                    bit_out_d   = 1'b1;
                end
            end
            SYNC: begin
                if (sync_cnt_q != 2'd3) begin
                    sync_cnt_d = sync_cnt_q + 2'd1;
                    bit_out_d  = 1'b1;
                end
            end
            ENDB: begin
                state_d = IDLE;
            end
            default: ;
        endcase

        if (w_emit) begin
            state_d = DATA;
            if (w_run == 2'd2) begin
                run_d = 2'd0;
            end else if (bits_left_q != '0) begin
                bit_out_d   = shift_q[DATA_W-1];
                shift_d     = shift_q << 1;
                bits_left_d = bits_left_q - CNT_ONE;
                run_d       = shift_q[DATA_W-1] ? (w_run + 2'd1) : 2'd0;
            end else begin
                state_d = ENDB;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == ENDB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bits_left_q <= '0;
            run_q       <= 2'd0;
            sync_cnt_q  <= 2'd0;
            bit_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            run_q       <= run_d;
            sync_cnt_q  <= sync_cnt_d;
            bit_out_q   <= bit_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Directed self-checking bench for serial_frame_tx using
//               hand-computed frame bit patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              bit_out;
    logic              busy;
    logic              frame_done;

    int n_checks;
    int n_fail;

    serial_frame_tx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .bit_out    (bit_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s : got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Starts at a negedge in an IDLE cycle; returns at the negedge of the IDLE
    // cycle following END. Frame bits are packed MSB-first: bit k is exp[len-k].
    task automatic run_frame(input logic [DATA_W-1:0] data, input logic [31:0] exp,
                             input int len, input logic hold, input logic [DATA_W-1:0] next_data);
        tx_data  = data;
        tx_valid = 1'b1;
        check_eq("ready_before_accept", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_data = next_data;
        if (!hold) tx_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            check_eq($sformatf("bit_out[%0d] data=%0h", k, data), {31'd0, bit_out}, {31'd0, exp[len-k]});
            check_eq($sformatf("busy[%0d]", k), {31'd0, busy}, 32'd1);
            check_eq($sformatf("frame_done[%0d]", k), {31'd0, frame_done}, {31'd0, (k == len)});
            check_eq($sformatf("ready_low[%0d]", k), {31'd0, tx_ready}, 32'd0);
            @(negedge clk);
        end
        check_eq("idle_bit_out", {31'd0, bit_out}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("idle_ready", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq("gap_bit_out", {31'd0, bit_out}, 32'd0);
            check_eq("gap_busy", {31'd0, busy}, 32'd0);
            check_eq("gap_frame_done", {31'd0, frame_done}, 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_bit_out", {31'd0, bit_out}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_ready_low", {31'd0, tx_ready}, 32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // 0xA5 : 111 10100101 0
        run_frame(8'hA5, 32'h0000_0F4A, 12, 1'b0, 8'h3C);
        idle_cycles(1);
        // 0xFF : 111 110110110110 0
        run_frame(8'hFF, 32'h0000_FB6C, 16, 1'b0, 8'h00);
        idle_cycles(1);
        // 0x66 : 111 0110001100 0
        run_frame(8'h66, 32'h0000_3B18, 14, 1'b0, 8'hFF);
        idle_cycles(1);
        // 0x00 : 111 00000000 0
        run_frame(8'h00, 32'h0000_0E00, 12, 1'b0, 8'hFF);
        idle_cycles(2);

        // Held valid: 0x81 then 0x7E accepted after a single IDLE cycle.
        // 0x81 : 111 10000001 0 ; 0x7E : 111 01101101100 0
        run_frame(8'h81, 32'h0000_0F02, 12, 1'b1, 8'h7E);
        run_frame(8'h7E, 32'h0000_76D8, 15, 1'b0, 8'h00);
        idle_cycles(1);

        // Reset in DATA of 0xFF truncates the frame.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_bit_out", {31'd0, bit_out}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("mid_rst_ready_low", {31'd0, tx_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        idle_cycles(16);
        run_frame(8'hA5, 32'h0000_0F4A, 12, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout : simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
